// File: rtl/key_schedule.sv
// AES-128 key expansion, one round key per Next request.
// A single shared S-box substitutes RotWord(w3) one byte per cycle before the word mix.
module key_schedule (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic         Next,
    input  logic [127:0] Key_In,
    output logic [127:0] Key_Out,
    output logic [3:0]   Round,
    output logic         Ry_KS,
    output logic         Done
);

    typedef enum logic [1:0] {StIdle, StReady, StSub, StMix} state_e;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic         ry_q, ry_d;
    logic         done_q, done_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [31:0]  temp_q, temp_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w;
    logic [7:0]   sbox_in, sbox_out;
    logic [7:0]   rcon;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    assign rot_w = {w3[23:0], w3[31:24]};

    // Byte n of a word sits at bit offset 8*(3-n); ~cnt_q equals 3-n for a 2-bit counter.
    assign sbox_in  = rot_w[{~cnt_q, 3'b000} +: 8];
    assign sbox_out = SBOX[{~sbox_in, 3'b000} +: 8];

    always_comb begin
        rcon = 8'h00;
        case (round_q)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w0_n = w0 ^ temp_q ^ {rcon, 24'h000000};
    assign w1_n = w1 ^ w0_n;
    assign w2_n = w2 ^ w1_n;
    assign w3_n = w3 ^ w2_n;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        ry_d    = ry_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        temp_d  = temp_q;

        if (Start) begin
            // Restart wins over Next and aborts any round in flight.
            key_d   = Key_In;
            round_d = 4'd0;
            ry_d    = 1'b1;
            done_d  = 1'b0;
            state_d = StReady;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StReady: begin
                    if (Next && (round_q < 4'd10)) begin
                        ry_d    = 1'b0;
                        cnt_d   = 2'd0;
                        state_d = StSub;
                    end
                end
                StSub: begin
                    temp_d[{~cnt_q, 3'b000} +: 8] = sbox_out;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = StMix;
                    end
                end
                StMix: begin
                    key_d   = {w0_n, w1_n, w2_n, w3_n};
                    round_d = round_q + 4'd1;
                    ry_d    = 1'b1;
                    done_d  = (round_q == 4'd9);
                    state_d = StReady;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            key_q   <= '0;
            round_q <= '0;
            ry_q    <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            temp_q  <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            ry_q    <= ry_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            temp_q  <= temp_d;
        end
    end

    assign Key_Out = key_q;
    assign Round   = round_q;
    assign Ry_KS   = ry_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_key_schedule.sv
// Bench for key_schedule: expected round keys are queued at stimulus time and
// checked by a monitor each time the block presents a new key.
module tb_key_schedule;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   round;
        logic         done;
    } exp_t;

    localparam logic [127:0] K0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

    localparam logic [127:0] RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic         clk = 1'b0;
    logic         rst, start, next;
    logic [127:0] key_in;
    logic [127:0] key_out;
    logic [3:0]   round;
    logic         ry_ks, done;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    logic start_seen = 1'b0;
    logic prev_ry = 1'b0;

    key_schedule dut (
        .Clk    (clk),
        .Rst    (rst),
        .Start  (start),
        .Next   (next),
        .Key_In (key_in),
        .Key_Out(key_out),
        .Round  (round),
        .Ry_KS  (ry_ks),
        .Done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [127:0] k, input logic [3:0] r, input logic d);
        exp_t e;
        e.key   = k;
        e.round = r;
        e.done  = d;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_next();
        next = 1'b1;
        step();
        next = 1'b0;
    endtask

    task automatic wait_ry(output int n);
        n = 0;
        while (ry_ks !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic wait_lo(output int m);
        m = 0;
        while (ry_ks === 1'b1 && m < 20) begin
            step();
            m++;
        end
    endtask

    always @(posedge clk) start_seen <= start;

    // A new key is presented on a rising Ry_KS, or on any edge that sampled Start.
    always @(negedge clk) begin
        if (ry_ks === 1'b1 && (prev_ry !== 1'b1 || start_seen)) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_key: got key %h round %0d with nothing expected",
                         key_out, round);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk($sformatf("key_r%0d", e.round), key_out, e.key);
                chk($sformatf("round_r%0d", e.round), round, e.round);
                chk($sformatf("done_r%0d", e.round), done, e.done);
            end
        end
        prev_ry = ry_ks;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int m;
        rst    = 1'b1;
        start  = 1'b0;
        next   = 1'b0;
        key_in = '0;
        step();
        step();
        chk("reset_key", key_out, 128'h0);
        chk("reset_round", round, 0);
        chk("reset_ry", ry_ks, 0);
        chk("reset_done", done, 0);

        rst  = 1'b0;
        do_next();
        step();
        step();
        chk("idle_next_ry", ry_ks, 0);
        chk("idle_next_round", round, 0);

        key_in = K0;
        push(K0, 4'd0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ry", ry_ks, 1);

        for (int r = 1; r <= 10; r++) begin
            push(RK[r], 4'(r), r == 10);
            do_next();
            wait_ry(n);
            chk($sformatf("latency_r%0d", r), n, 5);
        end

        do_next();
        repeat (6) step();
        chk("eleventh_key", key_out, RK[10]);
        chk("eleventh_round", round, 10);
        chk("eleventh_ry", ry_ks, 1);
        chk("eleventh_done", done, 1);

        push(K0, 4'd0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        next  = 1'b1;
        for (int r = 1; r <= 10; r++) push(RK[r], 4'(r), r == 10);
        for (int r = 1; r <= 10; r++) begin
            wait_lo(m);
            chk($sformatf("held_gap_r%0d", r), m, 1);
            wait_ry(n);
            chk($sformatf("held_latency_r%0d", r), n, 5);
        end
        repeat (12) step();
        next = 1'b0;
        chk("held_final_round", round, 10);
        chk("held_final_key", key_out, RK[10]);

        push(K0, 4'd0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            push(RK[r], 4'(r), 1'b0);
            do_next();
            wait_ry(n);
        end
        chk("pre_restart_round", round, 3);
        key_in = K1;
        push(K1, 4'd0, 1'b0);
        start = 1'b1;
        next  = 1'b1;
        step();
        start = 1'b0;
        next  = 1'b0;
        chk("restart_round", round, 0);
        step();
        chk("restart_stays_ready", ry_ks, 1);

        push(K1R1, 4'd1, 1'b0);
        do_next();
        wait_ry(n);
        chk("k1_latency", n, 5);

        key_in = K0;
        do_next();
        step();
        chk("in_sub_ry", ry_ks, 0);
        push(K0, 4'd0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        chk("abort_key", key_out, K0);
        chk("abort_round", round, 0);
        chk("abort_ry", ry_ks, 1);

        do_next();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midsub_rst_key", key_out, 128'h0);
        chk("midsub_rst_round", round, 0);
        chk("midsub_rst_ry", ry_ks, 0);
        chk("midsub_rst_done", done, 0);
        do_next();
        repeat (8) step();
        chk("post_rst_ry", ry_ks, 0);
        chk("post_rst_round", round, 0);

        step();
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 The block SHALL have no parameters; it is fixed to AES-128 (10 rounds, 128-bit key).
REQ-002 Clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Rst  input  1  reset; synchronous and active-high.
REQ-004 Start  input  1  load Key_In and restart the schedule at round 0.
REQ-005 Next  input  1  request computation of the next round key.
REQ-006 Key_In  input  128  cipher key; byte 0 = Key_In[127:120], FIPS-197 order.
REQ-007 Key_Out  output  128  current round key, registered; feeds Key_ARK of the round-key-add stage.
REQ-008 Round  output  4  index of the round key currently on Key_Out (0..10).
REQ-009 Ry_KS  output  1  high while Key_Out/Round are valid and the block accepts Next.
REQ-010 Done  output  1  high while Round==10 and Ry_KS==1.

Function
REQ-011 Word layout SHALL be w0=Key_Out[127:96], w1=[95:64], w2=[63:32], w3=[31:0]; the MSB byte of each word is its byte 0.
REQ-012 FSM states SHALL be IDLE, READY, SUB, MIX.
REQ-013 IDLE: outputs hold; Next is ignored; Start -> READY.
REQ-014 Start sampled high in any state SHALL, at that edge: Key_Out<=Key_In, Round<=0, Ry_KS<=1, Done<=0, state<=READY, aborting any SUB/MIX in progress.
REQ-015 Start SHALL take priority over a simultaneous Next.
REQ-016 READY with Next=1, Start=0 and Round<10: at that edge Ry_KS<=0, byte counter<=0, state<=SUB.
REQ-017 READY with Next=1 and Round==10: Next SHALL be ignored; all outputs unchanged.
REQ-018 Next SHALL be ignored in IDLE, SUB and MIX; it is not queued.
REQ-019 SUB SHALL last exactly 4 cycles and use one shared S-box: on counter value n (0..3) it substitutes byte n of RotWord(w3) into a 32-bit temp register; counter increments; after n=3, state<=MIX.
REQ-020 RotWord(w3) SHALL be {w3[23:0], w3[31:24]}.
REQ-021 The S-box SHALL be the FIPS-197 forward S-box (e.g. 00->63, 53->ED, FF->16).
REQ-022 Rcon for the new round r=Round+1 SHALL be 01,02,04,08,10,20,40,80,1B,36 for r=1..10, XORed into byte 0 of temp.
REQ-023 MIX SHALL, in one edge: w0'=w0^temp^{Rcon,24'h0}; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'; Key_Out<={w0',w1',w2',w3'}; Round<=Round+1; Ry_KS<=1; state<=READY.
REQ-024 Latency: Next accepted at edge k -> new Key_Out, Round and Ry_KS=1 at edge k+5.
REQ-025 Key_Out and Round SHALL hold the previous round key and index throughout SUB/MIX; a consumer uses Key_Out only while Ry_KS=1.
REQ-026 Done SHALL be set at the MIX edge producing Round 10 and cleared by Start or Rst.
REQ-027 Round SHALL never exceed 10 and never wrap.

Reset
REQ-028 Rst high at an edge SHALL force state=IDLE, Key_Out=0, Round=0, Ry_KS=0, Done=0, byte counter=0, temp=0, regardless of Start/Next or current state.
REQ-029 Rst asserted mid-SUB/MIX SHALL discard the partial computation; Start is required to resume.

Verification
REQ-030 Start with Key_In=2b7e151628aed2a6abf7158809cf4f3c -> next edge Key_Out equals Key_In, Round=0, Ry_KS=1, Done=0.
REQ-031 Then one Next pulse -> Ry_KS low for 5 cycles, then Key_Out=a0fafe1788542cb123a339392a6c7605, Round=1.
REQ-032 Ten Next pulses, each sent when Ry_KS=1 -> Round=10, Key_Out=d014f9a8c9ee2589e13f0cc8b6630ca6, Done=1; an 11th Next leaves all outputs unchanged.
REQ-033 Next held high continuously from round 0 -> a new key every 5 cycles, Round 1..10, with no extra Next consumed during SUB/MIX.
REQ-034 Start and Next high together in READY at Round=3 -> Round=0, Key_Out=Key_In, Ry_KS=1; Start pulsed during SUB -> same restart, no corrupted key emitted.
REQ-035 Rst pulsed during SUB -> next edge all outputs 0 and state IDLE; Next then ignored until Start.
